// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the 64K x 8 system memory.
// The slave side is the arbiter; the master side is everything around it.
interface mem_arbiter_if;
    logic        REQ0, REQ1;
    logic        WE0, WE1;
    logic        LOCK0, LOCK1;
    logic [15:0] ADDR0, ADDR1;
    logic [7:0]  WDATA0, WDATA1;
    logic        GNT0, GNT1;
    logic        RVALID0, RVALID1;
    logic [7:0]  RDATA0, RDATA1;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DIN;
    logic [7:0]  MEM_DOUT;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, LOCK0, LOCK1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_DOUT,
        output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, MEM_WE, MEM_ADDR, MEM_DIN
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, LOCK0, LOCK1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_DOUT,
        input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, MEM_WE, MEM_ADDR, MEM_DIN
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port 64K x 8 memory: fixed priority to requester 0,
// starvation escape for requester 1, and a bus lock for atomic read-modify-write.
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);
    localparam int          NUM_REQ = 2;
    localparam logic [3:0]  WMAX    = 4'(MAX_WAIT);

    logic [NUM_REQ-1:0]         req, we, lock, gnt, rd_pend;
    logic [NUM_REQ-1:0][15:0]   addr;
    logic [NUM_REQ-1:0][7:0]    wdata;

    logic        lock_valid;
    logic        lock_owner;
    logic [3:0]  wait_cnt;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;

    assign req   = {bus.REQ1,   bus.REQ0};
    assign we    = {bus.WE1,    bus.WE0};
    assign lock  = {bus.LOCK1,  bus.LOCK0};
    assign addr  = {bus.ADDR1,  bus.ADDR0};
    assign wdata = {bus.WDATA1, bus.WDATA0};

    // A held lock shuts out the other side even when the owner leaves the bus idle.
    always_comb begin
        gnt = '0;
        if (lock_valid)
            gnt[lock_owner] = req[lock_owner];
        else if (&req)
            gnt = (wait_cnt == WMAX) ? 2'b10 : 2'b01;
        else
            gnt = req;
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_we   = we[i];
                mem_addr = addr[i];
                mem_din  = wdata[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            wait_cnt   <= '0;
            rd_pend    <= '0;
        end else begin
            rd_pend <= gnt & ~we;

            if (gnt[1])
                wait_cnt <= '0;
            else if (req[1] && wait_cnt != WMAX)
                wait_cnt <= wait_cnt + 4'd1;

            // gnt[1] doubles as the index of whichever requester was accepted.
            if (|gnt) begin
                if (lock[gnt[1]]) begin
                    lock_valid <= 1'b1;
                    lock_owner <= gnt[1];
                end else if (lock_valid && lock_owner == gnt[1]) begin
                    lock_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.GNT0     = gnt[0];
    assign bus.GNT1     = gnt[1];
    assign bus.RVALID0  = rd_pend[0];
    assign bus.RVALID1  = rd_pend[1];
    assign bus.RDATA0   = bus.MEM_DOUT;
    assign bus.RDATA1   = bus.MEM_DOUT;
    assign bus.MEM_WE   = mem_we;
    assign bus.MEM_ADDR = mem_addr;
    assign bus.MEM_DIN  = mem_din;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port synchronous 64K x 8 system memory between the 6502 core (requester 0) and a secondary master such as a loader/DMA/debug port (requester 1). It accepts at most one transfer per clock and drives the memory's WE/Address/DataIn. It routes the one-cycle-latency read data back to the issuing requester with a valid strobe. Requester 0 has fixed priority. A starvation counter and a bus-lock mechanism guarantee forward progress for requester 1 and atomic read-modify-write sequences for either side.

## Interface
- MAX_WAIT, 4, consecutive lost contended cycles after which requester 1 wins the next contended cycle; legal range 1..15.
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0, REQ1  in  1  transfer request, held until accepted.
- WE0, WE1  in  1  1 = write, 0 = read; valid with REQn.
- LOCK0, LOCK1  in  1  sampled on an accepted transfer: 1 = keep bus after this transfer.
- ADDR0, ADDR1  in  16  byte address.
- WDATA0, WDATA1  in  8  write data.
- GNT0, GNT1  out  1  combinational; transfer accepted at this rising edge when REQn & GNTn.
- RVALID0, RVALID1  out  1  registered; read data valid this cycle.
- RDATA0, RDATA1  out  8  read data; equals MEM_DOUT, meaningful only while RVALIDn.
- MEM_WE  out  1  to memory WE.
- MEM_ADDR  out  16  to memory Address.
- MEM_DIN  out  8  to memory DataIn.
- MEM_DOUT  in  8  from memory DataOut (registered inside memory, 1-cycle latency).

## Operation
- State: lock_valid, lock_owner (1 bit), wait_cnt (4 bits), rd_pend0, rd_pend1.
- Grant decision, evaluated each cycle in priority order:
  - If lock_valid, only lock_owner may be granted. The other requester's GNT stays 0 even if the bus idles.
  - Else, if only one REQ is high, grant it.
  - Else, if both are high, grant 1 when wait_cnt == MAX_WAIT, otherwise grant 0.
  - At most one GNT is high; GNTn is never high without REQn.
- Mux: MEM_WE, MEM_ADDR and MEM_DIN come from the granted requester. With no grant, MEM_WE = 0, MEM_ADDR = 0 and MEM_DIN = 0. The memory performs a harmless read of address 0 and no RVALID results.
- wait_cnt:
  - Reset to 0 when GNT1 is accepted.
  - Increments (saturating at MAX_WAIT) when REQ1 is high and GNT1 is low, including cycles lost to a lock.
  - Unchanged when REQ1 is low.
- Lock:
  - An accepted transfer with LOCKn = 1 sets lock_valid = 1 and lock_owner = n.
  - An accepted transfer by the owner with LOCKn = 0 clears lock_valid.
  - While locked, a non-owner request waits indefinitely. The lock overrides starvation priority.
- Read return: an accepted read by n sets rd_pend for the following cycle only. RVALIDn = rd_pend_n and RDATAn = MEM_DOUT.
- Writes produce no RVALID. A write and a read to the same address on back-to-back cycles is coherent, because memory is strictly in order.
- Reset: every registered output and state element is 0. That means RVALID0 = RVALID1 = 0, lock_valid = 0 and wait_cnt = 0. GNT/MEM outputs follow the combinational rules from cleared state.
- Reset mid-operation: a pending read return is dropped (RVALID low the next cycle) and any held lock is released.

## Timing
- Request to accept: 0 cycles when GNT is high in the same cycle.
- Read latency: data is on RDATAn with RVALIDn in cycle t+1 for a read accepted at the edge ending cycle t.
- Throughput: one transfer per cycle sustained. Back-to-back reads from alternating requesters yield RVALID0/RVALID1 on alternating cycles, never both high.
- Requester 1 worst-case wait with no lock held: MAX_WAIT contended cycles, granted on cycle MAX_WAIT+1.
- The lock takes effect on the cycle after the accepted LOCK=1 transfer and releases on the cycle after the accepted LOCK=0 transfer.

## Test plan
- Reset, then read by requester 0: mem[0x0000] = 0xA2; REQ0 = 1, WE0 = 0, ADDR0 = 0x0000 -> GNT0 = 1 the same cycle; RVALID0 = 1 and RDATA0 = 0xA2 the next cycle; RVALID1 stays 0.
- Write then read, requester 1: write 0x5A to 0x0108, then read 0x0108 on the next cycle -> RVALID1 with RDATA1 = 0x5A two cycles after the write accept; MEM_WE high for exactly one cycle.
- Starvation, MAX_WAIT = 4: REQ0 and REQ1 held continuously -> GNT0 for 4 cycles, GNT1 on the 5th, then the pattern repeats 4:1; wait_cnt returns to 0 after each GNT1.
- Read-modify-write lock: requester 0 reads 0x02FF with LOCK0 = 1, idles one cycle, then writes 0x11 with LOCK0 = 0, while REQ1 is held throughout -> GNT1 stays 0 until the cycle after the write is accepted; mem[0x02FF] = 0x11.
- Mid-operation reset: accept a read by requester 1 with LOCK1 = 1, then assert RST the next cycle -> RVALID1 = 0 after the reset edge, lock released, and a following REQ0 is granted immediately.
- Idle bus: both REQ low for 3 cycles -> MEM_WE = 0, MEM_ADDR = 0x0000, GNT0 = GNT1 = 0, no RVALID.
